// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - in-order writeback buffer feeding the register file write ports
// Ordering is kept by draining only from the head and never pairing two writes to one register.
module writeback_queue #(
  parameter int SUPER_SCALAR_WIDTH = 2,
  parameter int WORD_WIDTH         = 32,
  parameter int REG_ADDR_WIDTH     = 5,
  parameter int DEPTH              = 8,
  localparam int REQ_WIDTH         = 1 + REG_ADDR_WIDTH + WORD_WIDTH,
  localparam int PTR_WIDTH         = $clog2(DEPTH),
  localparam int CNT_WIDTH         = PTR_WIDTH + 1
) (
  input  logic                                               clk_in,
  input  logic                                               rst_in,
  input  logic [SUPER_SCALAR_WIDTH-1:0]                      result_valid_in,
  input  logic [SUPER_SCALAR_WIDTH-1:0][REG_ADDR_WIDTH-1:0]  result_reg_in,
  input  logic [SUPER_SCALAR_WIDTH-1:0][WORD_WIDTH-1:0]      result_data_in,
  output logic                                               result_ready_out,
  output logic [SUPER_SCALAR_WIDTH-1:0][REQ_WIDTH-1:0]       write_ports_reg_request_out,
  output logic [CNT_WIDTH-1:0]                               occupancy_out,
  output logic                                               empty_out
);

  localparam int W = SUPER_SCALAR_WIDTH;

  logic [PTR_WIDTH-1:0]            head_q, head_d;
  logic [PTR_WIDTH-1:0]            tail_q, tail_d;
  logic [CNT_WIDTH-1:0]            count_q, count_d;
  logic [W-1:0][REQ_WIDTH-1:0]     req_q, req_d;

  logic [REG_ADDR_WIDTH-1:0]       mem_reg_q  [DEPTH];
  logic [WORD_WIDTH-1:0]           mem_data_q [DEPTH];

  logic                            room_ok;
  logic [W-1:0]                    lane_take;
  logic [W-1:0][PTR_WIDTH-1:0]     lane_slot;
  logic [CNT_WIDTH-1:0]            enq_cnt;
  logic [W-1:0][PTR_WIDTH-1:0]     peek_idx;
  logic [CNT_WIDTH-1:0]            drain_cnt;
  logic                            stop;
  logic                            collide;

  // Ready depends only on the registered count, so producers see no path from their own valid.
  assign room_ok          = (CNT_WIDTH'(DEPTH) - count_q) >= CNT_WIDTH'(W);
  assign result_ready_out = room_ok && !rst_in;

  always_comb begin
    enq_cnt   = '0;
    lane_take = '0;
    lane_slot = '0;
    for (int i = 0; i < W; i++) begin
      lane_slot[i] = tail_q + PTR_WIDTH'(enq_cnt);
      lane_take[i] = result_ready_out && result_valid_in[i] && (result_reg_in[i] != '0);
      if (lane_take[i]) begin
        enq_cnt = enq_cnt + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    peek_idx = '0;
    for (int p = 0; p < W; p++) begin
      peek_idx[p] = head_q + PTR_WIDTH'(p);
    end
  end

  // Selection is contiguous from the head, so earlier ports hold exactly entries head..head+p-1.
  always_comb begin
    req_d     = '0;
    drain_cnt = '0;
    stop      = 1'b0;
    collide   = 1'b0;
    for (int p = 0; p < W; p++) begin
      collide = 1'b0;
      for (int q = 0; q < W; q++) begin
        if (q < p && mem_reg_q[peek_idx[q]] == mem_reg_q[peek_idx[p]]) begin
          collide = 1'b1;
        end
      end
      if (!stop && (CNT_WIDTH'(p) < count_q) && !collide) begin
        req_d[p]  = {1'b1, mem_reg_q[peek_idx[p]], mem_data_q[peek_idx[p]]};
        drain_cnt = drain_cnt + CNT_WIDTH'(1);
      end else begin
        stop = 1'b1;
      end
    end
  end

  always_comb begin
    head_d  = head_q + PTR_WIDTH'(drain_cnt);
    tail_d  = tail_q + PTR_WIDTH'(enq_cnt);
    count_d = count_q + enq_cnt - drain_cnt;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      req_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      req_q   <= req_d;
    end
  end

  // Storage needs no reset: entries are only read while covered by count_q.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < W; i++) begin
      if (lane_take[i]) begin
        mem_reg_q[lane_slot[i]]  <= result_reg_in[i];
        mem_data_q[lane_slot[i]] <= result_data_in[i];
      end
    end
  end

  assign write_ports_reg_request_out = req_q;
  assign occupancy_out               = count_q;
  assign empty_out                   = (count_q == '0);

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - scoreboard bench for writeback_queue
module tb_writeback_queue;
  localparam int W  = 2;
  localparam int WW = 32;
  localparam int RA = 5;
  localparam int D  = 8;
  localparam int RQ = 1 + RA + WW;

  typedef logic [W-1:0][RQ-1:0] ports_t;
  typedef struct { int cyc; ports_t ports; } exp_t;

  logic                    clk;
  logic                    rst;
  logic [W-1:0]            valid;
  logic [W-1:0][RA-1:0]    regs;
  logic [W-1:0][WW-1:0]    data;
  logic                    ready;
  ports_t                  req;
  logic [$clog2(D):0]      occ;
  logic                    empty;

  exp_t        sb[$];
  int          cyc;
  int          total_cnt;
  int          pass_cnt;
  logic [31:0] rf [32];

  writeback_queue #(
    .SUPER_SCALAR_WIDTH(W), .WORD_WIDTH(WW), .REG_ADDR_WIDTH(RA), .DEPTH(D)
  ) dut (
    .clk_in(clk), .rst_in(rst), .result_valid_in(valid), .result_reg_in(regs),
    .result_data_in(data), .result_ready_out(ready),
    .write_ports_reg_request_out(req), .occupancy_out(occ), .empty_out(empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic ok, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic logic [RQ-1:0] wr(input int r, input logic [31:0] d);
    logic [RA-1:0] rr;
    rr = r[RA-1:0];
    return {1'b1, rr, d};
  endfunction

  exp_t   mon_e;
  logic   mon_any;
  always @(negedge clk) begin
    if (!rst) begin
      mon_any = 1'b0;
      for (int p = 0; p < W; p++) begin
        if (req[p][RQ-1]) begin
          mon_any = 1'b1;
          check("no_reg0_write", req[p][RQ-2 -: RA] != '0, 128'(req[p][RQ-2 -: RA]), 128'(1));
          rf[req[p][RQ-2 -: RA]] = req[p][WW-1:0];
        end
      end
      if (mon_any) begin
        if (sb.size() == 0) begin
          check("unexpected_write", 1'b0, 128'(req), 128'(0));
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.cyc >= 0) check("write_cycle", cyc == mon_e.cyc, 128'(cyc), 128'(mon_e.cyc));
          check("write_ports", req == mon_e.ports, 128'(req), 128'(mon_e.ports));
        end
      end
    end
  end

  task automatic drive(input logic v0, input int r0, input logic [31:0] d0,
                       input logic v1, input int r1, input logic [31:0] d1);
    valid   = {v1, v0};
    regs[0] = r0[RA-1:0];
    regs[1] = r1[RA-1:0];
    data[0] = d0;
    data[1] = d1;
  endtask

  task automatic offer(input logic v0, input int r0, input logic [31:0] d0,
                       input logic v1, input int r1, input logic [31:0] d1, output int acc);
    int t;
    @(negedge clk);
    drive(v0, r0, d0, v1, r1, d1);
    t = 0;
    while (!ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ready) check("offer_timeout", 1'b0, 128'(ready), 128'(1));
    acc = cyc;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input int c, input logic [RQ-1:0] p0, input logic [RQ-1:0] p1);
    exp_t e;
    e.cyc      = c;
    e.ports[0] = p0;
    e.ports[1] = p1;
    sb.push_back(e);
  endtask

  initial begin
    int n, m, mc, g, t;
    logic mr, take;
    clk = 0; rst = 1; cyc = 0; total_cnt = 0; pass_cnt = 0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("reset_ready", ready == 1'b0, 128'(ready), 128'(0));
    check("reset_occ", occ == 0, 128'(occ), 128'(0));
    check("reset_empty", empty == 1'b1, 128'(empty), 128'(1));
    check("reset_ports", req == '0, 128'(req), 128'(0));
    repeat (2) @(negedge clk);
    rst = 0;

    // single write
    offer(1, 5, 32'hDEADBEEF, 0, 0, 0, n);
    push(n + 2, wr(5, 32'hDEADBEEF), '0);
    repeat (3) idle();
    check("single_empty_after", empty == 1'b1, 128'(empty), 128'(1));

    // register 0 dropped
    offer(1, 0, 32'h11, 1, 3, 7, n);
    push(n + 2, wr(3, 7), '0);
    idle();
    check("reg0_occ_peak", occ == 1, 128'(occ), 128'(1));
    repeat (3) idle();
    check("reg0_drained", occ == 0, 128'(occ), 128'(0));

    // same-cycle write-after-write
    offer(1, 4, 1, 1, 4, 2, n);
    push(n + 2, wr(4, 1), '0);
    push(n + 3, wr(4, 2), '0);
    repeat (5) idle();
    check("waw_final", rf[4] == 32'd2, 128'(rf[4]), 128'(2));

    // mixed groups, different registers share a cycle
    offer(1, 1, 32'hA, 1, 2, 32'hB, n);
    push(n + 2, wr(1, 32'hA), wr(2, 32'hB));
    offer(1, 1, 32'hC, 1, 3, 32'hD, m);
    push(n + 3, wr(1, 32'hC), wr(3, 32'hD));
    check("mixed_back_to_back", m == n + 1, 128'(m), 128'(n + 1));
    repeat (4) idle();

    // fill and backpressure on a single register
    for (int k = 1; k <= 16; k++) push(-1, wr(9, k), '0);
    mc = 0; g = 1; t = 0;
    while ((g <= 8 || mc > 0) && t < 100) begin
      @(negedge clk);
      mr = (D - mc) >= W;
      check("fill_ready", ready == mr, 128'(ready), 128'(mr));
      check("fill_occ", occ == mc, 128'(occ), 128'(mc));
      if (g <= 8) drive(1, 9, 2 * g - 1, 1, 9, 2 * g);
      else drive(0, 0, 0, 0, 0, 0);
      take = mr && (g <= 8);
      @(posedge clk);
      mc = mc + (take ? 2 : 0) - (mc > 0 ? 1 : 0);
      if (take) g++;
      t++;
    end
    if (g <= 8 || mc > 0) check("fill_timeout", 1'b0, 128'(g), 128'(9));
    repeat (3) idle();
    check("fill_sb_drained", sb.size() == 0, 128'(sb.size()), 128'(0));

    // reset in the middle of operation
    offer(1, 10, 1, 1, 10, 2, n);
    push(n + 2, wr(10, 1), '0);
    offer(1, 10, 3, 0, 0, 0, m);
    idle();
    check("rst_pre_occ", occ == 2, 128'(occ), 128'(2));
    #1 rst = 1;
    #1;
    check("rst_async_we", req == '0, 128'(req), 128'(0));
    check("rst_async_occ", occ == 0, 128'(occ), 128'(0));
    check("rst_async_ready", ready == 1'b0, 128'(ready), 128'(0));
    @(negedge clk);
    rst = 0;
    #1;
    check("rst_release_ready", ready == 1'b1, 128'(ready), 128'(1));
    check("rst_release_empty", empty == 1'b1, 128'(empty), 128'(1));
    repeat (6) idle();
    check("final_sb_empty", sb.size() == 0, 128'(sb.size()), 128'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
